// File: rtl/uart_pkg.sv
// UART shared definitions: receiver state type, oversampling default and the
// mid-bit sample positions used for majority voting. Shared with the transmitter.
package uart_pkg;

    localparam int unsigned OVERSAMPLE_DEFAULT = 8;

    // Counter values at which a bit is sampled for the 2-of-3 vote
    localparam int unsigned MID_SAMPLES [3] = '{3, 4, 5};

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitIdle
    } uart_rx_state_t;

    // 2-of-3 majority
    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single bit.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, loads RESET_VAL into both flops
//   d     : asynchronous input
//   q     : synchronized output (2 clk latency)
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            q      <= RESET_VAL;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1-style framing (DATA_BITS data bits, no parity, 1 stop bit).
//   clk, rst_n  : clock, asynchronous active-low reset (released synchronously)
//   baud_tick   : one-clk enable at OVERSAMPLE x baud rate
//   rx          : serial line, idle high
//   rx_data     : last accepted byte
//   rx_valid    : rx_data holds an unconsumed byte; cleared by rx_valid && rx_ready
//   rx_ready    : consumer ready
//   busy        : receiver not idle
//   frame_err   : one-clk pulse when the stop bit votes low
//   overrun_err : one-clk pulse when a completed byte is dropped
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEFAULT,
    parameter int unsigned DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 overrun_err
);

    localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [2:0] CNT_LAST = 3'(OVERSAMPLE - 1);
    localparam logic [2:0] CNT_S0   = 3'(MID_SAMPLES[0]);
    localparam logic [2:0] CNT_S1   = 3'(MID_SAMPLES[1]);
    localparam logic [2:0] CNT_S2   = 3'(MID_SAMPLES[2]);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    logic rst_n_sync;
    logic rx_s;

    // Reset asserts asynchronously, deasserts two clk edges after rst_n rises
    sync_2ff #(.RESET_VAL(1'b0)) u_rst_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (1'b1),
        .q     (rst_n_sync)
    );

    sync_2ff #(.RESET_VAL(1'b1)) u_rx_sync (
        .clk   (clk),
        .rst_n (rst_n_sync),
        .d     (rx),
        .q     (rx_s)
    );

    uart_rx_state_t       state_q, state_d;
    logic [2:0]           cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [2:0]           samp_q, samp_d;
    logic                 done_q, done_d;
    logic                 ferr_q, ferr_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ovr_q, ovr_d;
    logic                 handshake;

    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            samp_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            samp_q  <= samp_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    // Frame FSM; every decision is qualified by baud_tick
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        samp_d  = samp_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        if (baud_tick) begin
            if (cnt_q == CNT_S0) samp_d[0] = rx_s;
            if (cnt_q == CNT_S1) samp_d[1] = rx_s;
            if (cnt_q == CNT_S2) samp_d[2] = rx_s;
            unique case (state_q)
                StIdle: begin
                    if (!rx_s) begin
                        state_d = StStart;
                        cnt_d   = '0;
                    end
                end
                StStart: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (!maj3(samp_q)) begin
                            state_d = StData;
                            idx_d   = '0;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                StData: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        shift_d = {maj3(samp_q), shift_q[DATA_BITS-1:1]};
                        if (idx_q == IDX_LAST) state_d = StStop;
                        else                   idx_d   = idx_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                StStop: begin
                    // Decide at the last mid sample so a back-to-back start edge is not missed
                    if (cnt_q == CNT_S2) begin
                        cnt_d = '0;
                        if (maj3({rx_s, samp_q[1:0]})) begin
                            done_d  = 1'b1;
                            state_d = StIdle;
                        end else begin
                            ferr_d  = 1'b1;
                            shift_d = '0;
                            state_d = StWaitIdle;
                        end
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                StWaitIdle: begin
                    if (rx_s) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Output buffer: a completion coinciding with a handshake refills it without overrun
    always_comb begin
        handshake = valid_q & rx_ready;
        data_d    = data_q;
        valid_d   = valid_q;
        ovr_d     = 1'b0;
        if (handshake) valid_d = 1'b0;
        if (done_q) begin
            if (!valid_q || handshake) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    assign rx_data     = data_q;
    assign rx_valid    = valid_q;
    assign busy        = (state_q != StIdle);
    assign frame_err   = ferr_q;
    assign overrun_err = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames,
// checked against a transaction-level model of what the consumer should see.
module tb_uart_rx;

    localparam int unsigned DB   = 8;
    localparam int unsigned OVS  = 8;
    localparam int unsigned TDIV = 4;   // clk per baud_tick
    // Ticks from the tick edge preceding the start bit to the stop-bit decision:
    // 1 to see the (2-clk synchronized) falling edge, OVS for the start bit,
    // OVS per data bit, then counts 0..5 of the stop bit.
    localparam int unsigned STOP_DECIDE_TICKS = 1 + OVS + OVS * DB + 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          baud_tick = 1'b0;
    logic          rx = 1'b1;
    logic          rx_ready = 1'b1;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          busy;
    logic          frame_err;
    logic          overrun_err;

    uart_rx #(.OVERSAMPLE(OVS), .DATA_BITS(DB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .baud_tick   (baud_tick),
        .rx          (rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .busy        (busy),
        .frame_err   (frame_err),
        .overrun_err (overrun_err)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (TDIV - 1) @(posedge clk);
            #1 baud_tick = 1'b1;
            @(posedge clk);
            #1 baud_tick = 1'b0;
        end
    end

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor of what the consumer observes
    logic [DB-1:0] got_q[$];
    int            v_hi = 0, ferr_cnt = 0, ovr_cnt = 0, stab_err = 0;
    int unsigned   last_rise = 0;
    logic          prev_v = 1'b0, prev_hs = 1'b0;
    logic [DB-1:0] prev_data = '0;

    always @(negedge clk) begin
        if (rx_valid && rx_ready) got_q.push_back(rx_data);
        if (rx_valid && !prev_v) last_rise = cyc;
        if (rx_valid && prev_v && !prev_hs && rx_data != prev_data) stab_err++;
        if (rx_valid) v_hi++;
        if (frame_err) ferr_cnt++;
        if (overrun_err) ovr_cnt++;
        prev_v    = rx_valid;
        prev_hs   = rx_valid && rx_ready;
        prev_data = rx_data;
    end

    // Reference model: expected accepted bytes, held byte and error counts
    logic [DB-1:0] exp_q[$];
    logic          m_valid = 1'b0;
    logic [DB-1:0] m_data = '0;
    int            exp_ferr = 0, exp_ovr = 0;

    task automatic model_frame(input logic [DB-1:0] b, input logic stop);
        if (!stop) exp_ferr++;
        else if (rx_ready) exp_q.push_back(b);
        else if (!m_valid) begin
            m_valid = 1'b1;
            m_data  = b;
        end else exp_ovr++;
    endtask

    // Returns #1 after the n-th following clk edge that carries a tick
    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (baud_tick !== 1'b1) @(posedge clk);
        end
        #1;
    endtask

    // Call #1 after a tick edge; leaves rx at the stop-bit level
    task automatic send_frame(input logic [DB-1:0] b, input logic stop, output int unsigned t0);
        t0 = cyc;
        rx = 1'b0;
        wait_ticks(OVS);
        for (int i = 0; i < DB; i++) begin
            rx = b[i];
            wait_ticks(OVS);
        end
        rx = stop;
        wait_ticks(OVS);
        model_frame(b, stop);
    endtask

    task automatic check_last(input string tag);
        check_eq({tag, "_count"}, got_q.size(), exp_q.size());
        if (got_q.size() > 0 && exp_q.size() > 0)
            check_eq({tag, "_data"}, got_q[got_q.size()-1], exp_q[exp_q.size()-1]);
    endtask

    initial begin
        int unsigned t0;
        int          v0, f0, g0;
        logic [DB-1:0] b;
        logic        err, fs;
        int          gap;

        // Reset
        repeat (5) @(posedge clk);
        #1;
        check_eq("rst_valid", rx_valid, 0);
        check_eq("rst_data", rx_data, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_ferr", frame_err, 0);
        check_eq("rst_ovr", overrun_err, 0);
        rst_n = 1'b1;
        wait_ticks(4);

        // Single byte, latency and pulse width
        v0 = v_hi;
        send_frame(8'hA5, 1'b1, t0);
        rx = 1'b1;
        check_last("a5");
        check_eq("a5_vpulse", v_hi - v0, 1);
        check_eq("a5_latency", last_rise - t0, STOP_DECIDE_TICKS * TDIV + 1);
        check_eq("a5_ferr", ferr_cnt, 0);
        check_eq("a5_ovr", ovr_cnt, 0);
        wait_ticks(3);

        // False start
        v0 = v_hi;
        f0 = ferr_cnt;
        rx = 1'b0;
        wait_ticks(2);
        rx = 1'b1;
        wait_ticks(12);
        check_eq("fs_busy", busy, 0);
        check_eq("fs_valid", v_hi - v0, 0);
        check_eq("fs_ferr", ferr_cnt - f0, 0);
        send_frame(8'h3C, 1'b1, t0);
        rx = 1'b1;
        check_last("3c");
        wait_ticks(3);

        // Framing error followed by a break
        v0 = v_hi;
        g0 = got_q.size();
        send_frame(8'h55, 1'b0, t0);
        wait_ticks(8);
        check_eq("fe_busy_wait", busy, 1);
        check_eq("fe_ferr", ferr_cnt, exp_ferr);
        check_eq("fe_novalid", v_hi - v0, 0);
        check_eq("fe_nodata", got_q.size() - g0, 0);
        rx = 1'b1;
        wait_ticks(3);
        check_eq("fe_busy_rel", busy, 0);
        send_frame(8'h81, 1'b1, t0);
        rx = 1'b1;
        check_last("81");
        wait_ticks(3);

        // Overrun
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1, t0);
        send_frame(8'h22, 1'b1, t0);
        rx = 1'b1;
        wait_ticks(2);
        check_eq("ovr_cnt", ovr_cnt, exp_ovr);
        check_eq("ovr_valid", rx_valid, 1);
        check_eq("ovr_data", rx_data, m_data);
        rx_ready = 1'b1;
        exp_q.push_back(m_data);
        m_valid = 1'b0;
        @(posedge clk);
        #1;
        check_eq("ovr_clear", rx_valid, 0);
        check_last("ovr_hs");
        wait_ticks(2);

        // Back-to-back frames, no idle gap
        v0 = v_hi;
        send_frame(8'h00, 1'b1, t0);
        send_frame(8'hFF, 1'b1, t0);
        rx = 1'b1;
        check_eq("b2b_pulses", v_hi - v0, 2);
        check_eq("b2b_first", got_q.size() >= 2 ? got_q[got_q.size()-2] : 9'h1ff, 8'h00);
        check_last("b2b");
        wait_ticks(3);

        // Reset during data bit 4 of 0xF0
        b  = 8'hF0;
        rx = 1'b0;
        wait_ticks(OVS);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            wait_ticks(OVS);
        end
        rx = b[4];
        wait_ticks(4);
        rst_n = 1'b0;
        #1;
        check_eq("mrst_valid", rx_valid, 0);
        check_eq("mrst_data", rx_data, 0);
        check_eq("mrst_busy", busy, 0);
        check_eq("mrst_ferr", frame_err, 0);
        check_eq("mrst_ovr", overrun_err, 0);
        wait_ticks(2);
        rx = 1'b1;
        rst_n = 1'b1;
        v0 = v_hi;
        wait_ticks(20);
        check_eq("mrst_idle_busy", busy, 0);
        check_eq("mrst_novalid", v_hi - v0, 0);
        send_frame(8'h0F, 1'b1, t0);
        rx = 1'b1;
        check_last("0f");
        wait_ticks(3);

        // Randomized frames, occasional false starts and stop-bit errors
        for (int k = 0; k < 24; k++) begin
            b   = DB'($urandom);
            err = ($urandom_range(0, 9) == 0);
            fs  = ($urandom_range(0, 7) == 0);
            gap = $urandom_range(0, 3);
            if (fs) begin
                rx = 1'b0;
                wait_ticks($urandom_range(1, 2));
                rx = 1'b1;
                wait_ticks(12);
            end
            send_frame(b, !err, t0);
            rx = 1'b1;
            if (err && gap < 2) gap = 2;
            wait_ticks(gap);
        end
        wait_ticks(4);

        check_eq("final_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check_eq($sformatf("byte%0d", i), got_q[i], exp_q[i]);
        check_eq("final_ferr", ferr_cnt, exp_ferr);
        check_eq("final_ovr", ovr_cnt, exp_ovr);
        check_eq("data_stable", stab_err, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
